// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//
// Multi-cycle controller that drives a shared, purely combinational 16-bit
// Hack ALU for a single command requester. It runs one of two commands:
//   op 0 : one ALU pass using the caller's control bits
//   op 1 : 16x16 shift-and-add multiply (low 16 bits), built from ALU x+y
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_op, cmd_ctrl       command select, ALU control {zx,nx,zy,ny,f,no}
//   cmd_a, cmd_b           operand x / multiplicand, operand y / multiplier
//   res_valid/res_ready    result handshake
//   res_data/res_zr/res_ng result word and its zero / negative flags
//   busy                   high whenever the sequencer is not idle
//   alu_x/alu_y/alu_ctrl   operands and control driven to the ALU
//   alu_out/alu_zr/alu_ng  ALU result and flags, captured on the clock edge
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command, ALU outputs parked at 0
// EXEC  | single ALU pass with caller operands and control
// ADD   | prod + mcand on the ALU, kept only when mplier[0] is set
// DBL   | mcand + mcand on the ALU, shift mplier, count the iteration
// DONE  | result held until the requester takes it

module alu_mul_sequencer #(
    parameter int MUL_ITERS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [5:0]  cmd_ctrl,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_zr,
    output logic        res_ng,
    output logic        busy,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctrl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_ADD,
        S_DBL,
        S_DONE
    } state_t;

    localparam logic [5:0]  CTRL_ADD  = 6'b000010;
    localparam int          IW        = 5;
    localparam logic [IW-1:0] LAST_ITER = IW'(MUL_ITERS - 1);

    state_t        state;
    state_t        state_nx;

    logic [15:0]   opx_q;
    logic [15:0]   opy_q;
    logic [5:0]    ctrl_q;
    logic [15:0]   prod_q;
    logic [15:0]   mcand_q;
    logic [15:0]   mplier_q;
    logic [IW-1:0] iter_q;
    logic          last_iter;

    assign last_iter = (iter_q == LAST_ITER);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake and ALU drive come only from the state and registered
    // operands, so cmd_ready/res_valid have no path from cmd_* or alu_*.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        alu_x     = 16'h0000;
        alu_y     = 16'h0000;
        alu_ctrl  = 6'b000000;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nx = cmd_op ? S_ADD : S_EXEC;
                end
            end
            S_EXEC: begin
                alu_x    = opx_q;
                alu_y    = opy_q;
                alu_ctrl = ctrl_q;
                state_nx = S_DONE;
            end
            S_ADD: begin
                alu_x    = prod_q;
                alu_y    = mcand_q;
                alu_ctrl = CTRL_ADD;
                state_nx = S_DBL;
            end
            S_DBL: begin
                alu_x    = mcand_q;
                alu_y    = mcand_q;
                alu_ctrl = CTRL_ADD;
                state_nx = last_iter ? S_DONE : S_ADD;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opx_q    <= 16'h0000;
            opy_q    <= 16'h0000;
            ctrl_q   <= 6'b000000;
            prod_q   <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            iter_q   <= '0;
            res_data <= 16'h0000;
            res_zr   <= 1'b0;
            res_ng   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        opx_q    <= cmd_a;
                        opy_q    <= cmd_b;
                        ctrl_q   <= cmd_ctrl;
                        prod_q   <= 16'h0000;
                        mcand_q  <= cmd_a;
                        mplier_q <= cmd_b;
                        iter_q   <= '0;
                    end
                end
                S_EXEC: begin
                    res_data <= alu_out;
                    res_zr   <= alu_zr;
                    res_ng   <= alu_ng;
                end
                S_ADD: begin
                    // The ALU cycle is spent even when the bit is clear so
                    // that latency does not depend on the multiplier.
                    if (mplier_q[0]) begin
                        prod_q <= alu_out;
                    end
                end
                S_DBL: begin
                    mcand_q  <= alu_out;
                    mplier_q <= mplier_q >> 1;
                    iter_q   <= iter_q + IW'(1);
                    if (last_iter) begin
                        res_data <= prod_q;
                        res_zr   <= (prod_q == 16'h0000);
                        res_ng   <= prod_q[15];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

    localparam int M = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [5:0]  cmd_ctrl;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_zr;
    logic        res_ng;
    logic        busy;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.MUL_ITERS(M)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ctrl  (cmd_ctrl),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zr    (res_zr),
        .res_ng    (res_ng),
        .busy      (busy),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_zr    (alu_zr),
        .alu_ng    (alu_ng)
    );

    // Behavioural Hack ALU
    function automatic logic [15:0] hack(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    always_comb begin
        alu_out = hack(alu_x, alu_y, alu_ctrl);
        alu_zr  = (alu_out == 16'h0000);
        alu_ng  = alu_out[15];
    end

    // Reference multiply: plain arithmetic on the used multiplier bits
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] mask, p;
        mask = (32'd1 << M) - 32'd1;
        p    = {16'h0000, a} * ({16'h0000, b} & mask);
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic op, input logic [5:0] ctrl,
                        input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ctrl  = ctrl;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_ctrl  = 6'($urandom);
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_cmd(input logic op, input logic [5:0] ctrl,
                          input logic [15:0] a, input logic [15:0] b, input int stall);
        int n;
        logic [15:0] e;
        e = op ? ref_mul(a, b) : hack(a, b, ctrl);
        send(op, ctrl, a, b);
        wait_result(n);
        chk("latency", n, op ? 2 * M : 1);
        chk("res_data", res_data, e);
        chk("res_zr", res_zr, (e == 16'h0000));
        chk("res_ng", res_ng, e[15]);
        chk("ready_in_done", cmd_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, e);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("valid_cleared", res_valid, 0);
        chk("ready_idle", cmd_ready, 1);
        chk("data_kept", res_data, e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_zr"}, res_zr, 0);
        chk({tag, "_res_ng"}, res_ng, 0);
        chk({tag, "_alu_x"}, alu_x, 0);
        chk({tag, "_alu_y"}, alu_y, 0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] held;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_ctrl  = 6'b0;
        cmd_a     = 16'h0;
        cmd_b     = 16'h0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_cmd(1'b0, 6'b000010, 16'd5, 16'd7, 0);
        do_cmd(1'b0, 6'b010011, 16'd3, 16'd3, 1);
        do_cmd(1'b0, 6'b010011, 16'd3, 16'd4, 0);
        do_cmd(1'b1, 6'b000000, 16'd123, 16'd45, 2);
        do_cmd(1'b1, 6'b000000, 16'h0100, 16'h0100, 0);
        do_cmd(1'b1, 6'b000000, 16'hFFFF, 16'hFFFF, 0);
        do_cmd(1'b1, 6'b000000, 16'h0000, 16'h1234, 0);

        // Randomized commands
        for (int i = 0; i < 24; i++) begin
            do_cmd(1'($urandom), 6'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // Back-pressure with a pending command held on the input
        send(1'b1, 6'b000000, 16'd1234, 16'd77);
        wait_result(n);
        chk("bp_latency", n, 2 * M);
        held = ref_mul(16'd1234, 16'd77);
        chk("bp_data", res_data, held);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_ctrl  = 6'b000010;
        cmd_a     = 16'd9;
        cmd_b     = 16'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", res_data, held);
            chk("bp_hold_ready", cmd_ready, 0);
            chk("bp_hold_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_release_valid", res_valid, 0);
        chk("bp_release_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_accept_busy", busy, 1);
        chk("bp_accept_ready", cmd_ready, 0);
        wait_result(n);
        chk("bp_new_latency", n, 1);
        chk("bp_new_data", res_data, 16'd10);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset during ADD at iteration 7
        send(1'b1, 6'b000000, 16'd123, 16'd45);
        repeat (14) @(posedge clk);
        #1;
        chk("it7_alu_ctrl", alu_ctrl, 6'b000010);
        chk("it7_alu_x", alu_x, ref_mul(16'd123, 16'd45 & 16'h007F));
        chk("it7_alu_y", alu_y, 16'(16'd123 << 7));
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_valid", res_valid, 0);
        do_cmd(1'b1, 6'b000000, 16'd2, 16'd3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that sequences the 16-bit Hack ALU (external, purely combinational) on behalf of one command requester.
- Supports two commands: a single ALU pass with caller-supplied control bits, and a 16x16 shift-and-add multiply.
- The multiply is built entirely from ALU "x+y" operations.
- Sits between the CPU's extended-op path and the shared ALU. Drives the ALU operands and control; captures ALU results on the clock edge.

Parameters:
- MUL_ITERS, 16, number of multiplier bits processed (1..16); only b[MUL_ITERS-1:0] is used.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0 = single ALU pass, 1 = multiply
- cmd_ctrl  in  6  ALU control for op 0, bit order {zx,nx,zy,ny,f,no} = [5:0]
- cmd_a  in  16  operand x / multiplicand
- cmd_b  in  16  operand y / multiplier
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- res_data  out  16  result
- res_zr  out  1  res_data == 0
- res_ng  out  1  res_data[15]
- busy  out  1  high in any state other than IDLE
- alu_x  out  16  ALU x operand
- alu_y  out  16  ALU y operand
- alu_ctrl  out  6  ALU control {zx,nx,zy,ny,f,no}
- alu_out  in  16  ALU result (combinational from alu_x/alu_y/alu_ctrl)
- alu_zr  in  1  ALU zero flag
- alu_ng  in  1  ALU negative flag

Behaviour:
- States: IDLE, EXEC, ADD, DBL, DONE.
- Reset (async, reset_n=0): state = IDLE; cmd_ready=1; res_valid=0; res_data=0; res_zr=0; res_ng=0; busy=0; alu_x=0; alu_y=0; alu_ctrl=0. Reset asserted mid-operation abandons the operation with no result.
- IDLE:
  - cmd_ready=1; ALU outputs driven to 0.
  - On handshake, latch a, b, ctrl and op.
  - op 0 goes to EXEC.
  - op 1 goes to ADD with prod=0, mcand=a, mplier=b, iter=0.
- EXEC (1 cycle):
  - Drive alu_x=a, alu_y=b, alu_ctrl=ctrl.
  - At the edge: res_data=alu_out, res_zr=alu_zr, res_ng=alu_ng; go to DONE.
- ADD:
  - Drive alu_x=prod, alu_y=mcand, alu_ctrl=6'b000010 (x+y).
  - At the edge: prod=alu_out only if mplier[0]=1, otherwise prod is unchanged. The ALU cycle is spent either way, so latency is fixed.
  - Go to DBL.
- DBL:
  - Drive alu_x=mcand, alu_y=mcand, alu_ctrl=6'b000010.
  - At the edge: mcand=alu_out; mplier shifts right 1; iter increments.
  - If iter == MUL_ITERS-1 before the increment, go to DONE and load res_data=prod, res_zr=(prod==0), res_ng=prod[15]. Otherwise go to ADD.
- Multiply arithmetic:
  - Modulo 2^16: the low 16 bits of a*b; overflow is silently discarded.
  - Signed and unsigned low halves are identical.
- DONE:
  - res_valid=1; res_data, res_zr and res_ng are held stable until the handshake.
  - cmd_ready=0; ALU outputs 0.
  - On res_valid & res_ready, go to IDLE and clear res_valid.
  - res_data keeps its last value after the handshake.
- Latency, with the command accepted in cycle N:
  - op 0: res_valid in cycle N+2.
  - op 1: res_valid in cycle N+1+2*MUL_ITERS, i.e. N+33 at the default.
  - Latency is independent of operand values.
- No overlap: a new command is never accepted while busy or while a result is pending. cmd_valid held high is accepted in the first IDLE cycle after the result handshake.
- All outputs come from registers or the state decode; there is no combinational path from cmd_* or alu_* inputs to cmd_ready or res_valid.
- cmd_* inputs may change freely after acceptance.

Test Plan:
- Reset then op 0: ctrl=000010, a=5, b=7 → res_valid at N+2; res_data=12, zr=0, ng=0.
- Op 0: ctrl=010011 (x-y), a=3, b=3 → res_data=0, zr=1. Then a=3, b=4 → res_data=0xFFFF, ng=1.
- Op 1: a=123, b=45 → res_valid exactly at N+33; res_data=5535, zr=0, ng=0.
- Op 1 overflow and zero cases:
  - a=0x0100, b=0x0100 → res_data=0, zr=1.
  - a=0xFFFF, b=0xFFFF → res_data=1.
  - a=0, b=0x1234 → res_data=0, zr=1.
- Back-pressure: hold res_ready=0 for 10 cycles with cmd_valid high → res_data stable, cmd_ready=0, no new accept. Raise res_ready → IDLE next cycle, new command accepted the cycle after.
- Drop reset_n during ADD at iter 7 → immediate IDLE with all outputs 0. After release, a fresh op 1 with a=2, b=3 → res_data=6 at N+33.
